// File: rtl/mii_rx_sfd_timestamper_if.sv
// Timestamp read-out handshake between the SFD timestamper and the time-sync consumer.
interface mii_rx_sfd_timestamper_if;
    logic        ts_valid;
    logic        ts_ready;
    logic [31:0] ts_second;
    logic [31:0] ts_nanosecond;

    modport master (
        output ts_valid,
        output ts_second,
        output ts_nanosecond,
        input  ts_ready
    );

    modport slave (
        input  ts_valid,
        input  ts_second,
        input  ts_nanosecond,
        output ts_ready
    );
endinterface

// File: rtl/mii_rx_sfd_timestamper.sv
// MII receive tap: fixed-delay pass-through to the MAC, SFD detection, corrected
// timestamp capture and a show-ahead timestamp FIFO with sticky overflow.
module mii_rx_sfd_timestamper #(
    parameter int unsigned DelayStages_Gen    = 2,
    parameter int unsigned TsFifoDepth_Gen    = 4,
    parameter int unsigned TsCorrectionNs_Gen = 0
) (
    input  logic                            clk_clk,
    input  logic                            reset_reset_n,
    input  logic [3:0]                      phy_rx_d,
    input  logic                            phy_rx_dv,
    input  logic                            phy_rx_err,
    output logic [3:0]                      mac_rx_d,
    output logic                            mac_rx_dv,
    output logic                            mac_rx_err,
    input  logic [31:0]                     time_second_in,
    input  logic [31:0]                     time_nanosecond_in,
    mii_rx_sfd_timestamper_if.master        ts,
    output logic                            ts_overflow,
    input  logic                            ts_overflow_clr
);
    localparam int unsigned AddrW    = (TsFifoDepth_Gen > 1) ? $clog2(TsFifoDepth_Gen) : 1;
    localparam logic [31:0] NsPerSec = 32'd1000000000;
    localparam logic [31:0] CorrNs   = 32'(TsCorrectionNs_Gen);
    localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(TsFifoDepth_Gen);

    typedef enum logic [1:0] {StDrop, StIdle, StPre, StFrame} state_e;

    // Pass-through delay line, {err, dv, d} per stage.
    logic [5:0] pipe_q [DelayStages_Gen];

    // Shift the receive pins through the delay line.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < int'(DelayStages_Gen); i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= {phy_rx_err, phy_rx_dv, phy_rx_d};
            for (int i = 1; i < int'(DelayStages_Gen); i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign {mac_rx_err, mac_rx_dv, mac_rx_d} = pipe_q[DelayStages_Gen-1];

    state_e state_q, state_d;
    logic   sfd_hit;

    // Preamble/SFD tracker state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state_q <= StDrop;
        else                state_q <= state_d;
    end

    // Next state; an SFD only counts after a clean preamble that started from idle.
    always_comb begin
        state_d = state_q;
        sfd_hit = 1'b0;
        case (state_q)
            StDrop: if (!phy_rx_dv) state_d = StIdle;
            StIdle: begin
                if (phy_rx_dv) state_d = (!phy_rx_err && phy_rx_d == 4'h5) ? StPre : StDrop;
            end
            StPre: begin
                if (!phy_rx_dv)             state_d = StIdle;
                else if (phy_rx_err)        state_d = StDrop;
                else if (phy_rx_d == 4'h5)  state_d = StPre;
                else if (phy_rx_d == 4'hD) begin
                    state_d = StFrame;
                    sfd_hit = 1'b1;
                end else                    state_d = StDrop;
            end
            StFrame: if (!phy_rx_dv) state_d = StIdle;
            default: state_d = StDrop;
        endcase
    end

    logic        cap_valid_q;
    logic [31:0] cap_sec_q, cap_ns_q;

    // Raw time capture on the SFD edge.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cap_valid_q <= 1'b0;
            cap_sec_q   <= '0;
            cap_ns_q    <= '0;
        end else begin
            cap_valid_q <= sfd_hit;
            if (sfd_hit) begin
                cap_sec_q <= time_second_in;
                cap_ns_q  <= time_nanosecond_in;
            end
        end
    end

    // Both operands are below 1e9, so the sum never exceeds 31 bits.
    logic [31:0] ns_sum, corr_ns, corr_sec;
    logic        ns_wrap;

    // Correction with a single carry into seconds.
    always_comb begin
        ns_sum   = cap_ns_q + CorrNs;
        ns_wrap  = (ns_sum >= NsPerSec);
        corr_ns  = ns_wrap ? (ns_sum - NsPerSec) : ns_sum;
        corr_sec = cap_sec_q + {31'd0, ns_wrap};
    end

    logic        push_q;
    logic [31:0] push_sec_q, push_ns_q;

    // Register the corrected pair as a FIFO push request.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            push_q     <= 1'b0;
            push_sec_q <= '0;
            push_ns_q  <= '0;
        end else begin
            push_q <= cap_valid_q;
            if (cap_valid_q) begin
                push_sec_q <= corr_sec;
                push_ns_q  <= corr_ns;
            end
        end
    end

    logic [31:0]    mem_sec [TsFifoDepth_Gen];
    logic [31:0]    mem_ns  [TsFifoDepth_Gen];
    logic [AddrW-1:0] wptr_q, rptr_q;
    logic [AddrW:0] count_q;
    logic [31:0]    hold_sec_q, hold_ns_q;
    logic           pop, full, push_ok, ovf_set;

    assign pop     = ts.ts_valid && ts.ts_ready;
    assign full    = (count_q == DepthCnt);
    // A pop frees the slot the colliding push writes into.
    assign push_ok = push_q && (!full || pop);
    assign ovf_set = push_q && full && !pop;

    // Storage array; contents are only visible while counted valid.
    always_ff @(posedge clk_clk) begin
        if (push_ok) begin
            mem_sec[wptr_q] <= push_sec_q;
            mem_ns[wptr_q]  <= push_ns_q;
        end
    end

    // Pointers, occupancy, last-popped hold value and sticky overflow.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            hold_sec_q  <= '0;
            hold_ns_q   <= '0;
            ts_overflow <= 1'b0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop) begin
                rptr_q     <= rptr_q + 1'b1;
                hold_sec_q <= mem_sec[rptr_q];
                hold_ns_q  <= mem_ns[rptr_q];
            end
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (!push_ok && pop) count_q <= count_q - 1'b1;
            if (ovf_set)              ts_overflow <= 1'b1;
            else if (ts_overflow_clr) ts_overflow <= 1'b0;
        end
    end

    assign ts.ts_valid      = (count_q != '0);
    assign ts.ts_second     = ts.ts_valid ? mem_sec[rptr_q] : hold_sec_q;
    assign ts.ts_nanosecond = ts.ts_valid ? mem_ns[rptr_q]  : hold_ns_q;
endmodule
